// File: rtl/adder_sum_pipe.sv
// Two-stage pipelined add/sub/slt/sltu unit with a Kogge-Stone carry network.
// Optional flag outputs are built only when ADDER_FLAGS_EN is defined.

// Parallel-prefix carry network; carry_network[i] is the carry out of bit i.
// Purely combinational, zero latency, no flow control.
module kogge_stone #(
  parameter int nbits = 32
) (
  input  logic [nbits-1:0] op1,
  input  logic [nbits-1:0] op2,
  input  logic             cin,
  output logic [nbits-1:0] carry_network,
  output logic [nbits-1:0] prop_op
);
  localparam int levels = $clog2(nbits);

  logic [levels:0][nbits-1:0] g;
  logic [levels:0][nbits-1:0] p;

  always_comb begin
    g = '0;
    p = '0;
    p[0] = op1 ^ op2;
    g[0] = op1 & op2;
    // Fold the carry-in into bit 0 so every prefix group ending at 0 sees it.
    g[0][0] = (op1[0] & op2[0]) | ((op1[0] ^ op2[0]) & cin);
    for (int k = 0; k < levels; k++) begin
      for (int i = 0; i < nbits; i++) begin
        if (i >= (1 << k)) begin
          g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
          p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
        end else begin
          g[k+1][i] = g[k][i];
          p[k+1][i] = p[k][i];
        end
      end
    end
  end

  assign carry_network = g[levels];
  assign prop_op       = op1 ^ op2;
endmodule

// Integer add/sub/compare pipeline (ADDER_FLAGS_EN enables flags_o).
// Latency: 2 cycles input transfer to valid_o; 1 op/cycle throughput.
// Backpressure: ready_o = ~v1 | ~v2 | ready_i; output held stable while stalled.
module adder_sum_pipe #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [nbits-1:0] op1_i,
  input  logic [nbits-1:0] op2_i,
  input  logic [1:0]       op_sel_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [nbits-1:0] result_o,
  output logic [3:0]       flags_o
);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  logic [nbits-1:0] a1;
  logic [nbits-1:0] b1;
  logic             cin1;
  logic [1:0]       sel1;
  logic             v1;
  logic             v2;

  logic             adv1;
  logic             in_xfer;
  logic [nbits-1:0] carry;
  logic [nbits-1:0] prop;
  logic [nbits-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [nbits-1:0] res_next;

  assign adv1    = ~v2 | ready_i;
  assign ready_o = ~v1 | adv1;
  assign in_xfer = valid_i & ready_o;
  assign valid_o = v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1   <= '0;
      b1   <= '0;
      cin1 <= 1'b0;
      sel1 <= '0;
      v1   <= 1'b0;
    end else if (in_xfer) begin
      a1   <= op1_i;
      b1   <= (op_sel_i == OP_ADD) ? op2_i : ~op2_i;
      cin1 <= (op_sel_i != OP_ADD);
      sel1 <= op_sel_i;
      v1   <= 1'b1;
    end else if (adv1) begin
      v1   <= 1'b0;
    end
  end

  kogge_stone #(.nbits(nbits)) u_ks (
    .op1           (a1),
    .op2           (b1),
    .cin           (cin1),
    .carry_network (carry),
    .prop_op       (prop)
  );

  assign sum  = prop ^ {carry[nbits-2:0], cin1};
  assign cout = carry[nbits-1];
  assign ovf  = carry[nbits-1] ^ carry[nbits-2];

  always_comb begin
    res_next = sum;
    if (sel1 == OP_SLT) begin
      res_next    = '0;
      res_next[0] = sum[nbits-1] ^ ovf;
    end else if (sel1 == OP_SLTU) begin
      res_next    = '0;
      res_next[0] = ~cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      result_o <= '0;
    end else if (adv1) begin
      v2       <= v1;
      result_o <= res_next;
    end
  end

`ifdef ADDER_FLAGS_EN
  // Flags describe the raw sum even for compares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_o <= '0;
    end else if (adv1) begin
      flags_o <= {(sum == '0), sum[nbits-1], ovf, cout};
    end
  end
`else
  assign flags_o = 4'b0000;
`endif
endmodule

// File: tb/tb_adder_sum_pipe.sv
// Scoreboard bench for adder_sum_pipe: directed corners plus randomized traffic.
module tb_adder_sum_pipe;
  localparam int NB = 32;
`ifdef ADDER_FLAGS_EN
  localparam bit FLG_EN = 1'b1;
`else
  localparam bit FLG_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NB-1:0] res;
    logic [3:0]    flg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [NB-1:0] op1_i;
  logic [NB-1:0] op2_i;
  logic [1:0]    op_sel_i;
  logic          valid_o;
  logic          ready_i;
  logic [NB-1:0] result_o;
  logic [3:0]    flags_o;

  int   tests = 0;
  int   fails = 0;
  bit   rand_rdy = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  adder_sum_pipe #(.nbits(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .op_sel_i (op_sel_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic straight from the operation definitions.
  function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [1:0] sel);
    exp_t          e;
    logic [NB:0]   w;
    logic [NB-1:0] s;
    logic          sub, c, ovf;
    sub = (sel != 2'b00);
    if (sub) begin
      s   = a - b;
      c   = (a >= b);
      ovf = (a[NB-1] != b[NB-1]) && (s[NB-1] != a[NB-1]);
    end else begin
      w   = {1'b0, a} + {1'b0, b};
      s   = w[NB-1:0];
      c   = w[NB];
      ovf = (a[NB-1] == b[NB-1]) && (s[NB-1] != a[NB-1]);
    end
    case (sel)
      2'b10:   e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      2'b11:   e.res = (a < b) ? 1 : 0;
      default: e.res = s;
    endcase
    e.flg = {(s == 0), s[NB-1], ovf, c};
    return e;
  endfunction

  function automatic logic [NB-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got result %h with no op outstanding", result_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_result", result_o, e.res);
        check("sb_flags", flags_o, FLG_EN ? e.flg : 4'b0000);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_i = ($urandom_range(3) != 0);
  endtask

  task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [1:0] sel);
    op1_i = a; op2_i = b; op_sel_i = sel; valid_i = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (ready_o) begin
        q.push_back(model(a, b, sel));
        tick();
        valid_i = 1'b0;
        return;
      end
      tick();
    end
    valid_i = 1'b0;
    check("send_timeout", 1, 0);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 500 && q.size() != 0; n++) tick();
    check(name, q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    op1_i = '0; op2_i = '0; op_sel_i = 2'b00;
    #12;
    check("rst_valid_o", valid_o, 0);
    check("rst_result_o", result_o, 0);
    check("rst_flags_o", flags_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready_o", ready_o, 1);
    tick();

    // Latency and overflow corner
    op1_i = 32'h7FFF_FFFF; op2_i = 32'h1; op_sel_i = 2'b00; valid_i = 1'b1;
    @(negedge clk);
    check("lat_ready", ready_o, 1);
    q.push_back(model(32'h7FFF_FFFF, 32'h1, 2'b00));
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", valid_o, 0);
    tick();
    @(negedge clk);
    check("lat_cycle2_valid", valid_o, 1);
    check("ovf_result", result_o, 32'h8000_0000);
    check("ovf_flags", flags_o, FLG_EN ? 4'b0110 : 4'b0000);
    drain("drain_lat");

    send(32'h5, 32'h5, 2'b01);
    send(32'h0, 32'h1, 2'b01);
    send(32'hFFFF_FFFF, 32'h1, 2'b10);
    send(32'hFFFF_FFFF, 32'h1, 2'b11);
    drain("drain_directed");

    // Backpressure: fill both stages, hold, then release
    ready_i = 1'b0;
    send(1, 1, 2'b00);
    send(2, 2, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready_o", ready_o, 0);
      check("stall_valid_o", valid_o, 1);
      check("stall_result", result_o, 2);
      if (k < 2) tick();
    end
    tick();
    ready_i = 1'b1;
    send(3, 3, 2'b00);
    send(4, 4, 2'b00);
    drain("drain_stall");

    // Asynchronous reset with both stages full
    ready_i = 1'b0;
    send(9, 9, 2'b00);
    send(7, 1, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_o", valid_o, 0);
    check("arst_result_o", result_o, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready_o", ready_o, 1);
    ready_i = 1'b1;
    tick();
    send(32'hA, 32'h5, 2'b00);
    drain("drain_arst");

    // Random traffic with random gaps and backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) tick();
      send(rnd_op(), rnd_op(), 2'($urandom_range(3)));
    end
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
